// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: divider FSM encoding,
// default divider latency and the hard-wired zero register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_CYCLES_DEF = 33;
    localparam logic [4:0]  REG_ZERO       = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status into the controller, stall/flush controls out.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_ren;
    logic       id_rt_ren;
    logic       ex_load;
    logic       ex_regwen;
    logic [5:0] ex_wreg;
    logic       ex_div_start;
    logic       dmem_busy;
    logic       exc_flush;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_stall;
    logic       ex_mem_flush;
    logic       div_busy;
    logic       div_done;

    // Pipeline side: reports stage status, obeys stall/flush.
    modport master (
        output id_rs, id_rt, id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_wreg,
               ex_div_start, dmem_busy, exc_flush,
        input  pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, div_busy, div_done
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_wreg,
               ex_div_start, dmem_busy, exc_flush,
        output pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall,
               ex_mem_flush, div_busy, div_done
    );

endinterface

// File: rtl/div_occupancy_fsm.sv
// Tracks how long a DIV/DIVU occupies EX: start cycle, DIV_CYCLES-2 busy cycles,
// then a single done cycle in which the result is written.
module div_occupancy_fsm
    import pipe_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic ex_div_start_i,
    input  logic dmem_busy_i,
    input  logic exc_flush_i,
    output logic div_stall_o,
    output logic div_done_o,
    output logic div_busy_o
);

    localparam logic [CNT_W-1:0] LoadVal = CNT_W'(DIV_CYCLES - 2);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_dec = cnt_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_flush_i) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (ex_div_start_i && !dmem_busy_i) begin
                        cnt_d   = LoadVal;
                        // With a two-cycle divider there are no busy cycles at all.
                        state_d = (LoadVal == '0) ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_stall_o = ((state_q == DIV_IDLE) && ex_div_start_i && !dmem_busy_i) ||
                         (state_q == DIV_BUSY);
    assign div_done_o  = (state_q == DIV_DONE) && !exc_flush_i;
    assign div_busy_o  = (state_q != DIV_IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: exception flush > bus wait > divider > load-use.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               resetn,
    pipe_hazard_ctrl_if.slave  bus
);

    logic div_stall;
    logic div_done;
    logic div_busy;
    logic mem_stall;
    logic lu_hazard;
    logic rs_match;
    logic rt_match;

    div_occupancy_fsm #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_fsm (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .ex_div_start_i (bus.ex_div_start),
        .dmem_busy_i    (bus.dmem_busy),
        .exc_flush_i    (bus.exc_flush),
        .div_stall_o    (div_stall),
        .div_done_o     (div_done),
        .div_busy_o     (div_busy)
    );

    assign mem_stall = bus.dmem_busy;
    assign rs_match  = bus.id_rs_ren && (bus.id_rs == bus.ex_wreg[4:0]);
    assign rt_match  = bus.id_rt_ren && (bus.id_rt == bus.ex_wreg[4:0]);

    // Non-GPR targets (bit 5) and $zero never create a dependency.
    assign lu_hazard = bus.ex_load && bus.ex_regwen && !bus.ex_wreg[5] &&
                       (bus.ex_wreg[4:0] != REG_ZERO) && (rs_match || rt_match);

    always_comb begin
        bus.pc_stall     = 1'b0;
        bus.if_id_stall  = 1'b0;
        bus.id_ex_stall  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_stall = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.div_busy     = 1'b0;
        bus.div_done     = 1'b0;
        if (resetn) begin
            bus.pc_stall     = !bus.exc_flush && (mem_stall || div_stall || lu_hazard);
            bus.if_id_stall  = !bus.exc_flush && (mem_stall || div_stall || lu_hazard);
            bus.id_ex_stall  = !bus.exc_flush && (mem_stall || div_stall);
            bus.id_ex_flush  = bus.exc_flush || (lu_hazard && !mem_stall && !div_stall);
            bus.ex_mem_stall = !bus.exc_flush && mem_stall;
            // A held EX/MEM must not also take the divider bubble.
            bus.ex_mem_flush = bus.exc_flush || (div_stall && !mem_stall);
            bus.div_busy     = div_busy;
            bus.div_done     = div_done;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected output words,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

    // Output word: {pc, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
    //               div_busy, div_done}
    localparam logic [7:0] E_NONE   = 8'h00;
    localparam logic [7:0] E_LU     = 8'hD0;
    localparam logic [7:0] E_DSTART = 8'hE4;
    localparam logic [7:0] E_DBUSY  = 8'hE6;
    localparam logic [7:0] E_DDONE  = 8'h03;
    localparam logic [7:0] E_MEM    = 8'hE8;
    localparam logic [7:0] E_MEMDIV = 8'hEA;
    localparam logic [7:0] E_EXCB   = 8'h16;
    localparam logic [7:0] E_EXCI   = 8'h14;

    logic clk;
    logic resetn;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .DIV_CYCLES (33),
        .CNT_W      (6)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks;
    int         errors;

    logic [7:0] obs;
    assign obs = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.id_ex_flush,
                  bus.ex_mem_stall, bus.ex_mem_flush, bus.div_busy, bus.div_done};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks = checks + 1;
            if (obs !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got %b expected %b", n, obs, e);
            end
        end
    end

    task automatic clr();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_rs_ren    = 1'b0;
        bus.id_rt_ren    = 1'b0;
        bus.ex_load      = 1'b0;
        bus.ex_regwen    = 1'b0;
        bus.ex_wreg      = 6'd0;
        bus.ex_div_start = 1'b0;
        bus.dmem_busy    = 1'b0;
        bus.exc_flush    = 1'b0;
    endtask

    // Inputs are already applied; queue the expectation and advance one cycle.
    task automatic chk(input logic [7:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [5:0] wreg, input logic [4:0] rs, input logic rs_ren,
                          input logic [4:0] rt, input logic rt_ren);
        bus.ex_load   = 1'b1;
        bus.ex_regwen = 1'b1;
        bus.ex_wreg   = wreg;
        bus.id_rs     = rs;
        bus.id_rs_ren = rs_ren;
        bus.id_rt     = rt;
        bus.id_rt_ren = rt_ren;
    endtask

    initial begin
        int t;
        checks = 0;
        errors = 0;
        clr();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset forces every output low even with hostile inputs.
        bus.dmem_busy = 1'b1; bus.exc_flush = 1'b1; bus.ex_div_start = 1'b1;
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0);
        chk(E_NONE, "reset_forced_zero");
        clr(); resetn = 1'b1;
        chk(E_NONE, "post_reset_idle");

        // Load-use hazard variants.
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0);  chk(E_LU,   "lu_rs");
        clr();                                 chk(E_NONE, "lu_one_cycle");
        set_lu(6'd8, 5'd3, 1'b1, 5'd8, 1'b1);  chk(E_LU,   "lu_rt");
        set_lu(6'd8, 5'd3, 1'b1, 5'd8, 1'b0);  chk(E_NONE, "lu_rt_no_ren");
        set_lu(6'd0, 5'd0, 1'b1, 5'd0, 1'b1);  chk(E_NONE, "lu_reg_zero");
        set_lu(6'h28, 5'd8, 1'b1, 5'd0, 1'b0); chk(E_NONE, "lu_non_gpr");
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0); bus.ex_regwen = 1'b0;
        chk(E_NONE, "lu_no_regwen");
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0); bus.ex_load = 1'b0;
        chk(E_NONE, "lu_not_load");
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0); bus.dmem_busy = 1'b1;
        chk(E_MEM,  "lu_under_mem_wait");
        set_lu(6'd8, 5'd8, 1'b1, 5'd0, 1'b0); bus.exc_flush = 1'b1;
        chk(E_EXCI, "lu_under_exc");
        clr(); bus.exc_flush = 1'b1;           chk(E_EXCI, "exc_idle");
        clr(); bus.dmem_busy = 1'b1;           chk(E_MEM,  "mem_idle");
        clr();                                 chk(E_NONE, "quiet");

        // Plain divide.
        bus.ex_div_start = 1'b1;               chk(E_DSTART, "div_start");
        clr();
        for (int i = 0; i < 31; i++)           chk(E_DBUSY, "div_busy");
        chk(E_DDONE, "div_done");
        chk(E_NONE,  "div_after_done");

        // Bus wait in the middle of BUSY; start held high is ignored while busy.
        bus.ex_div_start = 1'b1;               chk(E_DSTART, "bw_start");
        for (int i = 1; i <= 31; i++) begin
            bus.dmem_busy = (i >= 5 && i <= 9);
            chk(bus.dmem_busy ? E_MEMDIV : E_DBUSY, "bw_busy");
        end
        clr();
        chk(E_DDONE, "bw_done_cycle33");
        chk(E_NONE,  "bw_idle");

        // Exception abort at BUSY cycle 10.
        bus.ex_div_start = 1'b1;               chk(E_DSTART, "ex_start");
        clr();
        for (int i = 1; i <= 9; i++)           chk(E_DBUSY, "ex_busy");
        bus.exc_flush = 1'b1;                  chk(E_EXCB, "ex_abort");
        clr();
        for (int i = 0; i < 30; i++)           chk(E_NONE, "ex_no_done");

        // Start blocked by bus wait.
        bus.ex_div_start = 1'b1; bus.dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++)            chk(E_MEM, "blk_wait");
        bus.dmem_busy = 1'b0;                  chk(E_DSTART, "blk_start");
        clr();
        for (int i = 0; i < 31; i++)           chk(E_DBUSY, "blk_busy");
        chk(E_DDONE, "blk_done");

        // Reset mid-division.
        bus.ex_div_start = 1'b1;               chk(E_DSTART, "rst_start");
        clr();
        for (int i = 1; i <= 4; i++)           chk(E_DBUSY, "rst_busy");
        resetn = 1'b0; bus.ex_div_start = 1'b1; chk(E_NONE, "rst_forced_zero");
        clr(); resetn = 1'b1;
        for (int i = 0; i < 32; i++)           chk(E_NONE, "rst_idle_no_done");
        bus.ex_div_start = 1'b1;               chk(E_DSTART, "rst_restart");
        clr();
        for (int i = 0; i < 31; i++)           chk(E_DBUSY, "rst_restart_busy");
        chk(E_DDONE, "rst_restart_done");

        t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
